// File: rtl/hazard_fwd_unit.sv
// Operand hazard unit: per-port bypass from N pipeline stages, load-use and
// long-latency scoreboard stall detection, plus stall statistics.
module hazard_fwd_unit #(
   parameter int DATA_W       = 32,
   parameter int RADDR_W      = 5,
   parameter int NUM_RD_PORTS = 2,
   parameter int NUM_STAGES   = 2,
   parameter int CNT_W        = 32
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_RD_PORTS-1:0]                rd_en_i,
   input  logic [NUM_RD_PORTS*RADDR_W-1:0]        rd_addr_i,
   input  logic [NUM_RD_PORTS*DATA_W-1:0]         rf_data_i,
   input  logic [NUM_STAGES-1:0]                  stg_we_i,
   input  logic [NUM_STAGES*RADDR_W-1:0]          stg_waddr_i,
   input  logic [NUM_STAGES*DATA_W-1:0]           stg_wdata_i,
   input  logic [NUM_STAGES-1:0]                  stg_load_i,
   input  logic                                   lu_issue_i,
   input  logic [RADDR_W-1:0]                     lu_waddr_i,
   input  logic                                   lu_done_i,
   input  logic [RADDR_W-1:0]                     lu_done_waddr_i,
   input  logic                                   lu_abort_i,
   output logic [NUM_RD_PORTS*DATA_W-1:0]         rd_data_o,
   output logic [NUM_RD_PORTS*(NUM_STAGES+1)-1:0] fwd_sel_o,
   output logic                                   stall_o,
   output logic                                   sb_conflict_o,
   output logic [RADDR_W:0]                       pending_cnt_o,
   output logic [CNT_W-1:0]                       stall_cnt_o
);

   localparam int NUM_REGS = 2**RADDR_W;
   localparam int SEL_W    = NUM_STAGES + 1;
   localparam logic [SEL_W-1:0] SEL_ONE = {{NUM_STAGES{1'b0}}, 1'b1};
   localparam logic [SEL_W-1:0] SEL_RF  = {1'b1, {NUM_STAGES{1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [RADDR_W:0] popcount(input logic [NUM_REGS-1:0] vec);
      logic [RADDR_W:0] cnt;
      cnt = {(RADDR_W+1){1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt = cnt + {{RADDR_W{1'b0}}, vec[i]};
      end
      return cnt;
   endfunction

   logic [NUM_REGS-1:0]              sb_r;
   logic [NUM_REGS-1:0]              sb_nxt_s;
   logic                             conflict_r;
   logic                             conflict_nxt_s;
   logic [RADDR_W:0]                 pending_cnt_r;
   logic [CNT_W-1:0]                 stall_cnt_r;
   logic                             issue_ok_s;
   logic [NUM_RD_PORTS-1:0]          port_stall_s;
   logic [NUM_RD_PORTS*DATA_W-1:0]   rd_data_s;
   logic [NUM_RD_PORTS*SEL_W-1:0]    fwd_sel_s;

   genvar gp;
   generate
      for (gp = 0; gp < NUM_RD_PORTS; gp++) begin : g_port
         logic [RADDR_W-1:0]    addr_s;
         logic                  addr_nz_s;
         logic [NUM_STAGES-1:0] hit_s;
         logic [DATA_W-1:0]     data_s;
         logic [SEL_W-1:0]      sel_s;
         logic                  load_s;

         assign addr_s    = rd_addr_i[gp*RADDR_W +: RADDR_W];
         assign addr_nz_s = |addr_s;

         // x0 never matches a stage, so it always resolves to zero from the regfile slot.
         for (genvar gs = 0; gs < NUM_STAGES; gs++) begin : g_hit
            assign hit_s[gs] = addr_nz_s && stg_we_i[gs] &&
                               (stg_waddr_i[gs*RADDR_W +: RADDR_W] == addr_s);
         end

         // Walk oldest to youngest so the youngest matching stage is applied last and wins.
         always_comb begin
            data_s = addr_nz_s ? rf_data_i[gp*DATA_W +: DATA_W] : {DATA_W{1'b0}};
            sel_s  = SEL_RF;
            load_s = 1'b0;
            for (int s = NUM_STAGES - 1; s >= 0; s--) begin
               data_s = hit_s[s] ? stg_wdata_i[s*DATA_W +: DATA_W] : data_s;
               sel_s  = hit_s[s] ? (SEL_ONE << s) : sel_s;
               load_s = hit_s[s] ? stg_load_i[s] : load_s;
            end
         end

         assign rd_data_s[gp*DATA_W +: DATA_W] = data_s;
         assign fwd_sel_s[gp*SEL_W +: SEL_W]   = sel_s;
         assign port_stall_s[gp] = rd_en_i[gp] && addr_nz_s && (load_s || sb_r[addr_s]);
      end
   endgenerate

   assign issue_ok_s = lu_issue_i && (|lu_waddr_i);

   // Scoreboard next state: abort dominates, then done clears, then issue sets.
   always_comb begin
      sb_nxt_s       = sb_r;
      conflict_nxt_s = 1'b0;
      if (lu_abort_i) begin
         sb_nxt_s = {NUM_REGS{1'b0}};
      end else begin
         sb_nxt_s[lu_done_waddr_i] = sb_nxt_s[lu_done_waddr_i] & ~lu_done_i;
         sb_nxt_s[lu_waddr_i]      = sb_nxt_s[lu_waddr_i] | issue_ok_s;
         conflict_nxt_s = issue_ok_s && sb_r[lu_waddr_i] &&
                          !(lu_done_i && (lu_done_waddr_i == lu_waddr_i));
      end
   end

   // State registers; pending count tracks the value the scoreboard is about to hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_r          <= {NUM_REGS{1'b0}};
         conflict_r    <= 1'b0;
         pending_cnt_r <= {(RADDR_W+1){1'b0}};
         stall_cnt_r   <= {CNT_W{1'b0}};
      end else begin
         sb_r          <= sb_nxt_s;
         conflict_r    <= conflict_nxt_s;
         pending_cnt_r <= popcount(sb_nxt_s);
         stall_cnt_r   <= (stall_o && (stall_cnt_r != CNT_MAX)) ? stall_cnt_r + CNT_ONE
                                                                : stall_cnt_r;
      end
   end

   assign rd_data_o     = rd_data_s;
   assign fwd_sel_o     = fwd_sel_s;
   assign stall_o       = |port_stall_s;
   assign sb_conflict_o = conflict_r;
   assign pending_cnt_o = pending_cnt_r;
   assign stall_cnt_o   = stall_cnt_r;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed scenarios plus random traffic,
// expectations from a behavioural model, checked by a decoupled negedge monitor.
module tb_hazard_fwd_unit;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NP = 2;
   localparam int NS = 2;
   localparam int CW = 4;
   localparam int SW = NS + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic [NP-1:0]      rd_en;
   logic [NP*AW-1:0]   rd_addr;
   logic [NP*DW-1:0]   rf_data;
   logic [NS-1:0]      stg_we;
   logic [NS*AW-1:0]   stg_waddr;
   logic [NS*DW-1:0]   stg_wdata;
   logic [NS-1:0]      stg_load;
   logic               lu_issue;
   logic [AW-1:0]      lu_waddr;
   logic               lu_done;
   logic [AW-1:0]      lu_done_waddr;
   logic               lu_abort;
   logic [NP*DW-1:0]   rd_data;
   logic [NP*SW-1:0]   fwd_sel;
   logic               stall;
   logic               sb_conflict;
   logic [AW:0]        pending_cnt;
   logic [CW-1:0]      stall_cnt;

   hazard_fwd_unit #(.DATA_W(DW), .RADDR_W(AW), .NUM_RD_PORTS(NP),
                     .NUM_STAGES(NS), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rf_data_i(rf_data),
      .stg_we_i(stg_we), .stg_waddr_i(stg_waddr), .stg_wdata_i(stg_wdata),
      .stg_load_i(stg_load), .lu_issue_i(lu_issue), .lu_waddr_i(lu_waddr),
      .lu_done_i(lu_done), .lu_done_waddr_i(lu_done_waddr), .lu_abort_i(lu_abort),
      .rd_data_o(rd_data), .fwd_sel_o(fwd_sel), .stall_o(stall),
      .sb_conflict_o(sb_conflict), .pending_cnt_o(pending_cnt), .stall_cnt_o(stall_cnt));

   typedef struct {
      logic [NP*DW-1:0] data;
      logic [NP*SW-1:0] sel;
      logic             stall;
      logic             conflict;
      logic [AW:0]      pend;
      logic [CW-1:0]    scnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests_run = 0;
   int   tests_failed = 0;

   // Reference state: set of pending registers, saturating stall count, conflict flag.
   bit   pend_m[2**AW];
   int   scnt_m = 0;
   bit   conf_m = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("rd_data", 64'(rd_data), 64'(mon_e.data));
         check("fwd_sel", 64'(fwd_sel), 64'(mon_e.sel));
         check("stall", 64'(stall), 64'(mon_e.stall));
         check("sb_conflict", 64'(sb_conflict), 64'(mon_e.conflict));
         check("pending_cnt", 64'(pending_cnt), 64'(mon_e.pend));
         check("stall_cnt", 64'(stall_cnt), 64'(mon_e.scnt));
      end
   end

   task automatic idle();
      rst = 1'b0; rd_en = '0; rd_addr = '0; rf_data = '0;
      stg_we = '0; stg_waddr = '0; stg_wdata = '0; stg_load = '0;
      lu_issue = 1'b0; lu_waddr = '0; lu_done = 1'b0; lu_done_waddr = '0; lu_abort = 1'b0;
   endtask

   // Predict this cycle's outputs, queue them, advance the model across the edge.
   task automatic step();
      exp_t e;
      bit   stall_v = 1'b0;
      int   popc = 0;
      int   a;
      int   src;
      int   iw;
      int   dw;
      e.data = '0;
      e.sel  = '0;
      for (int p = 0; p < NP; p++) begin
         a   = int'(rd_addr[p*AW +: AW]);
         src = NS;
         if (a != 0) begin
            for (int s = 0; s < NS; s++) begin
               if (src == NS && stg_we[s] && int'(stg_waddr[s*AW +: AW]) == a) src = s;
            end
         end
         if (a == 0) e.data[p*DW +: DW] = '0;
         else if (src < NS) e.data[p*DW +: DW] = stg_wdata[src*DW +: DW];
         else e.data[p*DW +: DW] = rf_data[p*DW +: DW];
         e.sel[p*SW + src] = 1'b1;
         if (rd_en[p] && a != 0 && ((src < NS && stg_load[src]) || pend_m[a])) stall_v = 1'b1;
      end
      for (int r = 0; r < 2**AW; r++) popc += int'(pend_m[r]);
      e.stall    = stall_v;
      e.conflict = conf_m;
      e.pend     = popc[AW:0];
      e.scnt     = scnt_m[CW-1:0];
      exp_q.push_back(e);

      iw = int'(lu_waddr);
      dw = int'(lu_done_waddr);
      if (rst) begin
         foreach (pend_m[r]) pend_m[r] = 1'b0;
         scnt_m = 0;
         conf_m = 1'b0;
      end else begin
         conf_m = 1'b0;
         if (lu_abort) begin
            foreach (pend_m[r]) pend_m[r] = 1'b0;
         end else begin
            if (lu_issue && iw != 0 && pend_m[iw] && !(lu_done && dw == iw)) conf_m = 1'b1;
            if (lu_done) pend_m[dw] = 1'b0;
            if (lu_issue && iw != 0) pend_m[iw] = 1'b1;
         end
         if (stall_v && scnt_m < 2**CW - 1) scnt_m++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      foreach (pend_m[r]) pend_m[r] = 1'b0;
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      step();                              // reset state
      idle();

      // Youngest stage wins on a double match.
      stg_we = 2'b11; stg_waddr = {5'd5, 5'd5}; stg_wdata = {32'hB, 32'hA};
      rd_en = 2'b01; rd_addr = {5'd0, 5'd5}; rf_data = {32'h1111, 32'h2222};
      step();
      // Reading x0 with a stage writing x0.
      idle(); stg_we = 2'b01; stg_waddr = {5'd0, 5'd0}; stg_wdata = {32'h0, 32'hFF};
      rd_en = 2'b11; rd_addr = {5'd0, 5'd0}; rf_data = {32'h33, 32'h44};
      step();
      // Load-use with and without rd_en.
      idle(); stg_we = 2'b01; stg_load = 2'b01; stg_waddr = {5'd0, 5'd7};
      stg_wdata = {32'h0, 32'h77}; rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
      step();
      rd_en = 2'b00;
      step();
      // Older stage load on port 1.
      idle(); stg_we = 2'b10; stg_load = 2'b10; stg_waddr = {5'd12, 5'd0};
      rd_en = 2'b10; rd_addr = {5'd12, 5'd0};
      step();

      // Long-latency issue x9, read until done at cycle 10 and one beyond.
      for (int c = 0; c <= 12; c++) begin
         idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
         lu_issue = (c == 0);  lu_waddr = 5'd9;
         lu_done = (c == 10);  lu_done_waddr = 5'd9;
         step();
      end
      // Double issue, done-to-clear bit, issue+done same reg, abort+issue.
      idle(); lu_issue = 1'b1; lu_waddr = 5'd3; step();
      step();
      idle(); lu_done = 1'b1; lu_done_waddr = 5'd20; step();
      idle(); lu_issue = 1'b1; lu_waddr = 5'd3; lu_done = 1'b1; lu_done_waddr = 5'd3; step();
      idle(); lu_issue = 1'b1; lu_waddr = 5'd0; step();
      idle(); lu_issue = 1'b1; lu_waddr = 5'd4; lu_abort = 1'b1; step();
      idle(); step();

      // Saturating stall counter.
      idle(); rst = 1'b1; step();
      for (int c = 0; c < 2**CW + 3; c++) begin
         idle(); stg_we = 2'b01; stg_load = 2'b01; stg_waddr = {5'd0, 5'd6};
         rd_en = 2'b01; rd_addr = {5'd0, 5'd6};
         step();
      end
      idle(); step();
      step();

      // Random traffic, including occasional resets and aborts.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         rd_en = NP'($urandom);
         for (int p = 0; p < NP; p++) begin
            rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            rf_data[p*DW +: DW] = $urandom;
         end
         for (int s = 0; s < NS; s++) begin
            stg_we[s] = ($urandom_range(0, 1) == 1);
            stg_load[s] = ($urandom_range(0, 3) == 0);
            stg_waddr[s*AW +: AW] = AW'($urandom_range(0, 7));
            stg_wdata[s*DW +: DW] = $urandom;
         end
         lu_issue = ($urandom_range(0, 9) < 3);
         lu_waddr = AW'($urandom_range(0, 7));
         lu_done = ($urandom_range(0, 9) < 3);
         lu_done_waddr = AW'($urandom_range(0, 7));
         lu_abort = ($urandom_range(0, 39) == 0);
         step();
      end
      idle();
      @(negedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
